draw_ship: RTL and testbench
============================

Name: draw_ship

Overview:
Downstream stage of the ship line ROM in the VGA drawing chain. Takes the VGA timing stream, computes the ship-relative row and drives it as the ROM address. Takes the registered 48-bit pixel line back from the ROM and overlays ship pixels onto the incoming RGB. Timing outputs are delayed so they stay aligned with rgb_out.

Parameters:
SHIP_W, 48, ship width in pixels; equals the ROM line width.
SHIP_H, 96, ship height in rows; the ROM holds rows 0..SHIP_H-1.
SHIP_COLOR, 12'h8_8_8, RGB444 colour of ship pixels.

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
xpos_in  in  11  requested ship left edge, in pixels
ypos_in  in  11  requested ship top edge, in rows
pos_valid  in  1  one-cycle strobe; xpos_in and ypos_in are valid
blink_in  in  1  blink request (used only with SHIP_BLINK_EN)
hcount_in  in  11  VGA horizontal count
vcount_in  in  11  VGA vertical count
hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  VGA timing
rgb_in  in  12  background colour
rom_addr  out  8  row address to the ship ROM
rom_pixels_in  in  48  ROM line data; arrives 1 cycle after rom_addr
hcount_out, vcount_out  out  11 each  delayed counts
hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed timing
rgb_out  out  12  composited colour

Behaviour:
- Reset (async, active-high):
  - all outputs 0, including rom_addr and rgb_out.
  - pending position = 0; active position = 0.
  - vblnk edge register = 0; frame counter = 0.
- Position double-buffering:
  - pos_valid=1 loads pending <= {xpos_in, ypos_in}. The last strobe before the update wins.
  - On the vblnk_in rising edge (vblnk_in=1 and registered previous value=0), active <= pending.
  - If pos_valid and the vblnk_in rising edge occur in the same cycle, active takes xpos_in/ypos_in directly.
  - The active position never changes outside that edge, so there is no tearing mid-frame.
- Arithmetic:
  - Box tests are 12-bit unsigned; no wrap.
  - in_row = (vcount_in >= ypos) and (vcount_in < ypos + SHIP_H).
  - in_col = (hcount_in >= xpos) and (hcount_in < xpos + SHIP_W).
  - A ship partially off-screen is simply clipped.
- Pipeline, 3 cycles fixed latency on every output:
  - S1 (registered):
    - rom_addr <= in_row ? (vcount_in - ypos)[7:0] : 0.
    - x_rel <= (hcount_in - xpos)[5:0].
    - in_box <= in_row & in_col.
    - Timing, counts and rgb_in are captured.
  - S2: ROM registers rom_pixels_in; the block delays x_rel, in_box, timing and rgb by one more stage.
  - S3 (registered output):
    - pix = rom_pixels_in[SHIP_W-1 - x_rel]; column 0 is the MSB.
    - If hblnk or vblnk (delayed) = 1: rgb_out = 0.
    - Else if in_box & pix & ~hide: rgb_out = SHIP_COLOR.
    - Else: rgb_out = rgb_in (delayed).
  - hide = 0 unless SHIP_BLINK_EN is defined.
- All timing and count outputs equal the corresponding inputs delayed by exactly 3 clk.
- Reset mid-frame: the pipeline clears immediately and outputs are 0. After release, valid data appears 3 cycles after inputs resume.

Optional Feature:
SHIP_BLINK_EN:
- Defined:
  - A 5-bit frame counter increments on each vblnk_in rising edge and wraps 31->0.
  - hide = blink_in & frame_cnt[4], giving 16 frames shown and 16 frames hidden.
  - blink_in is sampled at S1 and delayed with the pipeline.
- Not defined: no counter; blink_in is ignored; hide = 0.

Test Plan:
1. Reset: assert rst mid-line -> all outputs 0 in the same cycle. Release -> hsync_out follows hsync_in with exactly 3-cycle delay.
2. Placement, ROM model has row 0 = all ones:
   - pos_valid with x=100, y=50, then a vblnk rising edge.
   - At vcount=50: rgb_out = SHIP_COLOR for hcount 100..147 (observed 3 cycles later), and rgb_in at 99 and 148.
   - rom_addr = 0 at row 50 and 5 at row 55.
3. Double-buffer:
   - pos_valid x=200 mid-frame -> ship stays at x=100 until the next vblnk rise.
   - pos_valid on the same cycle as the vblnk rise -> new position takes effect that frame.
4. Bit order: ROM line = 48'h800000000001 -> ship colour only at x_rel=0 and x_rel=47.
5. Blanking and clipping:
   - Ship overlapping hblnk -> rgb_out = 0 there.
   - x=1000 -> columns beyond 1023 are absent; no wrap artefact at hcount 0..23.
6. SHIP_BLINK_EN, blink_in=1 -> ship visible frames 0–15, hidden frames 16–31, visible again at frame 32. blink_in=0 -> always visible.

Source files
------------

// File: rtl/draw_ship.sv
// Overlays a ROM-backed ship sprite on the VGA stream with a fixed 3-cycle latency.
// Optional blinking is enabled by defining SHIP_BLINK_EN.
module draw_ship #(
  parameter int          SHIP_W     = 48,
  parameter int          SHIP_H     = 96,
  parameter logic [11:0] SHIP_COLOR = 12'h8_8_8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] xpos_in,
  input  logic [10:0] ypos_in,
  input  logic        pos_valid,
  input  logic        blink_in,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [7:0]  rom_addr,
  input  logic [47:0] rom_pixels_in,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam int TW = 26;

  logic [21:0]   pending_q, pending_d;
  logic [21:0]   active_q, active_d;
  logic          vblnk_prev_q;
  logic          vblnk_rise_s;

  logic [11:0]   x_ext_s, y_ext_s, h_ext_s, v_ext_s;
  logic [11:0]   row_diff_s, col_diff_s;
  logic          in_row_s, in_col_s;
  logic [7:0]    rom_addr_d;
  logic [9:0]    diff_unused_s;

  logic [TW-1:0] tim_in_s, tim_s1_q, tim_s2_q;
  logic [11:0]   rgb_s1_q, rgb_s2_q, rgb_d;
  logic [5:0]    x_rel_s1_q, x_rel_s2_q;
  logic          in_box_s1_q, in_box_s2_q;
  logic [5:0]    bit_idx_s;
  logic          pix_s;
  logic          hide_s;

  assign vblnk_rise_s = vblnk_in & ~vblnk_prev_q;
  assign tim_in_s     = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};

  // Pending position tracks the latest strobe; active swaps only on the vblank rise.
  always_comb begin
    pending_d = pending_q;
    active_d  = active_q;
    if (pos_valid) begin
      pending_d = {xpos_in, ypos_in};
    end else begin
      pending_d = pending_q;
    end
    if (vblnk_rise_s) begin
      active_d = pos_valid ? {xpos_in, ypos_in} : pending_q;
    end else begin
      active_d = active_q;
    end
  end

  // Box tests are done 12 bits wide so ship edges near 2047 cannot wrap.
  always_comb begin
    x_ext_s    = {1'b0, active_q[21:11]};
    y_ext_s    = {1'b0, active_q[10:0]};
    h_ext_s    = {1'b0, hcount_in};
    v_ext_s    = {1'b0, vcount_in};
    row_diff_s = v_ext_s - y_ext_s;
    col_diff_s = h_ext_s - x_ext_s;
    in_row_s   = (v_ext_s >= y_ext_s) && (v_ext_s < (y_ext_s + 12'(SHIP_H)));
    in_col_s   = (h_ext_s >= x_ext_s) && (h_ext_s < (x_ext_s + 12'(SHIP_W)));
    if (in_row_s) begin
      rom_addr_d = row_diff_s[7:0];
    end else begin
      rom_addr_d = 8'd0;
    end
  end

  assign diff_unused_s = {row_diff_s[11:8], col_diff_s[11:6]};

  // Position buffers and the vblank edge detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= 22'd0;
      active_q     <= 22'd0;
      vblnk_prev_q <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      active_q     <= active_d;
      vblnk_prev_q <= vblnk_in;
    end
  end

`ifdef SHIP_BLINK_EN
  logic [4:0] frame_cnt_q, frame_cnt_d;
  logic       hide_s1_q, hide_s2_q;

  // Frame counter advances once per vblank rise and wraps naturally.
  always_comb begin
    if (vblnk_rise_s) begin
      frame_cnt_d = frame_cnt_q + 5'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Hide flag is captured at S1 and travels with the pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= 5'd0;
      hide_s1_q   <= 1'b0;
      hide_s2_q   <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      hide_s1_q   <= blink_in & frame_cnt_q[4];
      hide_s2_q   <= hide_s1_q;
    end
  end

  assign hide_s = hide_s2_q;
`else
  logic blink_unused_s;
  assign blink_unused_s = blink_in;
  assign hide_s         = 1'b0;
`endif

  // S1 and S2 stages; S2 lines up with the ROM's own output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr    <= 8'd0;
      x_rel_s1_q  <= 6'd0;
      in_box_s1_q <= 1'b0;
      tim_s1_q    <= '0;
      rgb_s1_q    <= 12'd0;
      x_rel_s2_q  <= 6'd0;
      in_box_s2_q <= 1'b0;
      tim_s2_q    <= '0;
      rgb_s2_q    <= 12'd0;
    end else begin
      rom_addr    <= rom_addr_d;
      x_rel_s1_q  <= col_diff_s[5:0];
      in_box_s1_q <= in_row_s & in_col_s;
      tim_s1_q    <= tim_in_s;
      rgb_s1_q    <= rgb_in;
      x_rel_s2_q  <= x_rel_s1_q;
      in_box_s2_q <= in_box_s1_q;
      tim_s2_q    <= tim_s1_q;
      rgb_s2_q    <= rgb_s1_q;
    end
  end

  // Column 0 of the sprite is the MSB of the ROM line.
  always_comb begin
    bit_idx_s = 6'(SHIP_W - 1) - x_rel_s2_q;
    pix_s     = rom_pixels_in[bit_idx_s];
    if (tim_s2_q[1] | tim_s2_q[0]) begin
      rgb_d = 12'd0;
    end else if (in_box_s2_q & pix_s & ~hide_s) begin
      rgb_d = SHIP_COLOR;
    end else begin
      rgb_d = rgb_s2_q;
    end
  end

  // S3 output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_out <= 11'd0;
      vcount_out <= 11'd0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= 12'd0;
    end else begin
      hcount_out <= tim_s2_q[25:15];
      vcount_out <= tim_s2_q[14:4];
      hsync_out  <= tim_s2_q[3];
      vsync_out  <= tim_s2_q[2];
      hblnk_out  <= tim_s2_q[1];
      vblnk_out  <= tim_s2_q[0];
      rgb_out    <= rgb_d;
    end
  end

endmodule

// File: tb/tb_draw_ship.sv
// Directed self-checking bench for draw_ship with a one-cycle ROM model.
module tb_draw_ship;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] xpos_in = 11'd0, ypos_in = 11'd0;
  logic        pos_valid = 1'b0, blink_in = 1'b0;
  logic [10:0] hcount_in = 11'd0, vcount_in = 11'd0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = 12'd0;
  logic [7:0]  rom_addr;
  logic [47:0] rom_pixels_in = 48'd0;
  logic [47:0] rom_line = {48{1'b1}};
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [11:0] SHIP = 12'h888;
  localparam logic [11:0] BG   = 12'h123;

  draw_ship dut (
    .clk(clk), .rst(rst), .xpos_in(xpos_in), .ypos_in(ypos_in), .pos_valid(pos_valid),
    .blink_in(blink_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .rom_addr(rom_addr), .rom_pixels_in(rom_pixels_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  // ROM stand-in: registered line, same content for every row.
  always @(posedge clk) rom_pixels_in <= rom_line;

  task automatic check_eq(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input string tag, input logic [10:0] h, input logic [10:0] v,
                     input logic [11:0] exp);
    hcount_in = h;
    vcount_in = v;
    repeat (3) step();
    check_eq(tag, rgb_out, exp);
  endtask

  task automatic frame_edge(input logic load, input logic [10:0] x, input logic [10:0] y);
    pos_valid = load;
    xpos_in   = x;
    ypos_in   = y;
    vblnk_in  = 1'b1;
    step();
    pos_valid = 1'b0;
    vblnk_in  = 1'b0;
    step();
  endtask

  task automatic load_pos(input logic [10:0] x, input logic [10:0] y);
    pos_valid = 1'b1;
    xpos_in   = x;
    ypos_in   = y;
    step();
    pos_valid = 1'b0;
  endtask

  initial begin
    rgb_in = BG;
    repeat (2) step();
    check_eq("reset_rgb", rgb_out, 12'd0);
    check_eq("reset_addr", rom_addr, 8'd0);
    rst = 1'b0;
    step();

    // Mid-line activity, then asynchronous reset.
    hcount_in = 11'd5; vcount_in = 11'd7; hsync_in = 1'b1;
    repeat (3) step();
    check_eq("pre_rst_hsync", hsync_out, 1'b1);
    check_eq("pre_rst_hcount", hcount_out, 11'd5);
    check_eq("pre_rst_rgb", rgb_out, SHIP);
    rst = 1'b1;
    #1;
    check_eq("rst_hsync", hsync_out, 1'b0);
    check_eq("rst_hcount", hcount_out, 11'd0);
    check_eq("rst_vcount", vcount_out, 11'd0);
    check_eq("rst_rgb", rgb_out, 12'd0);
    check_eq("rst_addr", rom_addr, 8'd0);
    hsync_in = 1'b0;
    step();
    rst = 1'b0;
    repeat (4) step();
    hsync_in = 1'b1;
    step();
    hsync_in = 1'b0;
    step();
    check_eq("hsync_d2", hsync_out, 1'b0);
    step();
    check_eq("hsync_d3", hsync_out, 1'b1);
    step();
    check_eq("hsync_d4", hsync_out, 1'b0);

    // Placement at (100,50).
    load_pos(11'd100, 11'd50);
    frame_edge(1'b0, 11'd0, 11'd0);
    pix("place_h99", 11'd99, 11'd50, BG);
    pix("place_h100", 11'd100, 11'd50, SHIP);
    check_eq("addr_row50", rom_addr, 8'd0);
    check_eq("hcount_out", hcount_out, 11'd100);
    check_eq("vcount_out", vcount_out, 11'd50);
    pix("place_h147", 11'd147, 11'd50, SHIP);
    pix("place_h148", 11'd148, 11'd50, BG);
    pix("place_row55", 11'd120, 11'd55, SHIP);
    check_eq("addr_row55", rom_addr, 8'd5);
    pix("place_row145", 11'd120, 11'd145, SHIP);
    pix("place_row146", 11'd120, 11'd146, BG);
    pix("above_row49", 11'd120, 11'd49, BG);
    check_eq("addr_outside", rom_addr, 8'd0);

    // Double buffering: mid-frame strobe waits for the vblank rise.
    load_pos(11'd200, 11'd50);
    pix("db_old_100", 11'd100, 11'd50, SHIP);
    pix("db_old_200", 11'd200, 11'd50, BG);
    frame_edge(1'b0, 11'd0, 11'd0);
    pix("db_new_100", 11'd100, 11'd50, BG);
    pix("db_new_200", 11'd200, 11'd50, SHIP);
    frame_edge(1'b1, 11'd300, 11'd50);
    pix("db_same_300", 11'd300, 11'd50, SHIP);
    pix("db_same_200", 11'd200, 11'd50, BG);

    // Bit order.
    rom_line = 48'h800000000001;
    pix("bit_x0", 11'd300, 11'd60, SHIP);
    pix("bit_x1", 11'd301, 11'd60, BG);
    pix("bit_x46", 11'd346, 11'd60, BG);
    pix("bit_x47", 11'd347, 11'd60, SHIP);
    rom_line = {48{1'b1}};

    // Blanking overrides the ship.
    hblnk_in = 1'b1;
    pix("hblnk_in_box", 11'd310, 11'd60, 12'd0);
    check_eq("hblnk_out", hblnk_out, 1'b1);
    hblnk_in = 1'b0;
    pix("hblnk_off", 11'd310, 11'd60, SHIP);

    // Clipping at the right edge, no wrap to column 0.
    frame_edge(1'b1, 11'd1000, 11'd50);
    pix("clip_1000", 11'd1000, 11'd60, SHIP);
    pix("clip_1023", 11'd1023, 11'd60, SHIP);
    pix("clip_wrap0", 11'd0, 11'd60, BG);
    pix("clip_wrap23", 11'd23, 11'd60, BG);

`ifdef SHIP_BLINK_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    blink_in = 1'b1;
    frame_edge(1'b1, 11'd100, 11'd50);
    pix("blink_f1", 11'd110, 11'd60, SHIP);
    for (int k = 2; k <= 32; k++) begin
      frame_edge(1'b0, 11'd0, 11'd0);
      pix($sformatf("blink_f%0d", k), 11'd110, 11'd60, ((k % 32) < 16) ? SHIP : BG);
    end
    for (int k = 0; k < 16; k++) frame_edge(1'b0, 11'd0, 11'd0);
    blink_in = 1'b0;
    pix("blink_off_f16", 11'd110, 11'd60, SHIP);
`else
    blink_in = 1'b1;
    for (int k = 0; k < 20; k++) frame_edge(1'b0, 11'd0, 11'd0);
    pix("noblink_f20", 11'd1010, 11'd60, SHIP);
    blink_in = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
